chunk_loader: RTL and testbench

CHUNK_LOADER -- requirements
Module: chunk_loader

---
 rtl/chunk_loader.sv | 162 ++++++++++++++++
 tb/tb_chunk_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/chunk_loader.sv
// rtl/chunk_loader.sv - buffers message words into 16-word chunks with MD5-style padding and length for the cruncher
// Optional feature: define CHUNK_LOADER_CNT_EN to count issued chunks on chunk_count.
module chunk_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  in_nbytes,
  output logic        crunch_start,
  input  logic        crunch_done,
  input  logic [3:0]  gaddr,
  output logic [31:0] mdata,
  output logic        msg_done,
  output logic [15:0] chunk_count
);

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_LEN,
    S_START,
    S_WAIT,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_buf [16];
  logic [3:0]  r_widx;
  logic [63:0] r_bitlen;
  logic        r_pad_done;
  logic        r_final;
  logic        r_last_seen;
  logic        r_in_ready;
  logic        r_crunch_start;
  logic        r_msg_done;

  logic        w_wrap;
  logic [5:0]  w_add_bits;
  logic [31:0] w_store_word;

  // A write at index 15 fills the chunk, so the index wraps and the chunk is ready.
  assign w_wrap = (r_widx == 4'd15);

  // A short final word contributes 8 bits per valid byte; every other word is 32 bits.
  assign w_add_bits = (in_last && (in_nbytes != 2'd0)) ? 6'({in_nbytes, 3'b000}) : 6'd32;

  // Short final word: keep valid bytes, place the 0x80 marker right after them, clear the rest.
  always_comb begin
    w_store_word = in_data;
    if (in_last) begin
      case (in_nbytes)
        2'd1:    w_store_word = {16'h0000, 8'h80, in_data[7:0]};
        2'd2:    w_store_word = {8'h00, 8'h80, in_data[15:0]};
        2'd3:    w_store_word = {8'h80, in_data[23:0]};
        default: w_store_word = in_data;
      endcase
    end
  end

  // Loader FSM: fill, pad, append length, hand the chunk to the cruncher and wait for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_FILL;
      r_widx         <= 4'd0;
      r_bitlen       <= 64'd0;
      r_pad_done     <= 1'b0;
      r_final        <= 1'b0;
      r_last_seen    <= 1'b0;
      r_in_ready     <= 1'b1;
      r_crunch_start <= 1'b0;
      r_msg_done     <= 1'b0;
    end else begin
      r_crunch_start <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (in_valid) begin
            r_buf[r_widx] <= w_store_word;
            r_bitlen      <= r_bitlen + 64'(w_add_bits);
            r_widx        <= r_widx + 4'd1;
            if (in_last) begin
              r_last_seen <= 1'b1;
              if (in_nbytes != 2'd0) r_pad_done <= 1'b1;
            end
            if (w_wrap) begin
              r_state        <= S_START;
              r_crunch_start <= 1'b1;
              r_in_ready     <= 1'b0;
            end else if (in_last) begin
              r_state    <= S_PAD;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_PAD: begin
          // Once the marker is in and only the length slots remain, switch to LEN.
          if (r_pad_done && (r_widx == 4'd14)) begin
            r_state <= S_LEN;
          end else begin
            r_buf[r_widx] <= r_pad_done ? 32'h0000_0000 : 32'h0000_0080;
            r_pad_done    <= 1'b1;
            r_widx        <= r_widx + 4'd1;
            if (w_wrap) begin
              r_state        <= S_START;
              r_crunch_start <= 1'b1;
            end
          end
        end
        S_LEN: begin
          r_buf[r_widx] <= (r_widx == 4'd14) ? r_bitlen[31:0] : r_bitlen[63:32];
          r_widx        <= r_widx + 4'd1;
          if (w_wrap) begin
            r_final        <= 1'b1;
            r_state        <= S_START;
            r_crunch_start <= 1'b1;
          end
        end
        S_START: r_state <= S_WAIT;
        // crunch_done may still be high from the previous chunk here, so it is not looked at.
        S_WAIT:  r_state <= S_BUSY;
        S_BUSY: begin
          if (crunch_done) begin
            r_widx <= 4'd0;
            if (r_final) begin
              r_state    <= S_DONE;
              r_msg_done <= 1'b1;
            end else if (r_last_seen) begin
              r_state <= S_PAD;
            end else begin
              r_state    <= S_FILL;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign crunch_start = r_crunch_start;
  assign msg_done     = r_msg_done;
  assign mdata        = r_buf[gaddr];

`ifdef CHUNK_LOADER_CNT_EN
  logic [15:0] r_chunk_count;

  // Count every start pulse handed to the cruncher, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) r_chunk_count <= 16'd0;
    else if (r_crunch_start) r_chunk_count <= r_chunk_count + 16'd1;
  end

  assign chunk_count = r_chunk_count;
`else
  assign chunk_count = 16'd0;
`endif

endmodule

// File: tb/tb_chunk_loader.sv
// tb/tb_chunk_loader.sv - directed self-checking bench for chunk_loader
`timescale 1ns/1ps
module tb_chunk_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        in_last = 1'b0;
  logic [1:0]  in_nbytes = 2'd0;
  logic        crunch_start;
  logic        crunch_done = 1'b0;
  logic [3:0]  gaddr = 4'd0;
  logic [31:0] mdata;
  logic        msg_done;
  logic [15:0] chunk_count;

  int total = 0;
  int bad = 0;
  int n_starts = 0;
  int base = 0;

`ifdef CHUNK_LOADER_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  chunk_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
    .crunch_start(crunch_start), .crunch_done(crunch_done), .gaddr(gaddr),
    .mdata(mdata), .msg_done(msg_done), .chunk_count(chunk_count)
  );

  always #5 clk = ~clk;

  // Count start pulses seen at each rising edge.
  always @(posedge clk) if (crunch_start === 1'b1) n_starts++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; crunch_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [1:0] nb);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_nbytes = nb;
    while (in_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $error("FAIL send_timeout observed=%0h expected=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int t;
    t = 0;
    while (crunch_start !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    if (crunch_start !== 1'b1) begin
      total++; bad++;
      $error("FAIL %s start_timeout observed=%0h expected=1", tag, crunch_start);
    end
  endtask

  task automatic wait_msg_done(input string tag);
    int t;
    t = 0;
    while (msg_done !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    if (msg_done !== 1'b1) begin
      total++; bad++;
      $error("FAIL %s done_timeout observed=%0h expected=1", tag, msg_done);
    end
  endtask

  task automatic rd(input int idx, input logic [31:0] exp, input string tag);
    gaddr = 4'(idx);
    #1;
    chk(tag, {32'd0, mdata}, {32'd0, exp});
  endtask

  task automatic release_chunk();
    repeat (3) @(negedge clk);
    crunch_done = 1'b1;
    @(negedge clk);
    crunch_done = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_start", {63'd0, crunch_start}, 64'd0);
    chk("rst_msg_done", {63'd0, msg_done}, 64'd0);
    chk("rst_count", {48'd0, chunk_count}, 64'd0);

    // "abc": one chunk
    base = n_starts;
    send(32'h00636261, 1'b1, 2'd3);
    wait_start("abc");
    rd(0, 32'h80636261, "abc_b0");
    rd(1, 32'h0, "abc_b1");
    rd(13, 32'h0, "abc_b13");
    rd(14, 32'h18, "abc_b14");
    rd(15, 32'h0, "abc_b15");
    release_chunk();
    wait_msg_done("abc");
    chk("abc_msg_done", {63'd0, msg_done}, 64'd1);
    chk("abc_in_ready", {63'd0, in_ready}, 64'd0);
    chk("abc_count", {48'd0, chunk_count}, CNT ? 64'd1 : 64'd0);
    chk("abc_starts", 64'(n_starts - base), 64'd1);

    // 5 bytes: short last word with nbytes=1, garbage upper bytes masked
    do_reset();
    send(32'h44332211, 1'b0, 2'd0);
    send(32'hAABBCC55, 1'b1, 2'd1);
    wait_start("b5");
    rd(0, 32'h44332211, "b5_b0");
    rd(1, 32'h00008055, "b5_b1");
    rd(2, 32'h0, "b5_b2");
    rd(14, 32'h28, "b5_b14");
    rd(15, 32'h0, "b5_b15");
    release_chunk();
    wait_msg_done("b5");

    // 2 bytes: nbytes=2
    do_reset();
    send(32'h9988BBAA, 1'b1, 2'd2);
    wait_start("b2");
    rd(0, 32'h0080BBAA, "b2_b0");
    rd(14, 32'h10, "b2_b14");
    release_chunk();
    wait_msg_done("b2");

    // 56 bytes: padding spills into a second chunk
    do_reset();
    base = n_starts;
    for (int i = 0; i < 14; i++) send(32'(32'h11111111 * (i + 1)), (i == 13), 2'd0);
    wait_start("b56_c1");
    rd(0, 32'h11111111, "b56_c1_b0");
    rd(13, 32'hEEEEEEEE, "b56_c1_b13");
    rd(14, 32'h80, "b56_c1_b14");
    rd(15, 32'h0, "b56_c1_b15");
    release_chunk();
    wait_start("b56_c2");
    for (int i = 0; i < 14; i++) rd(i, 32'h0, $sformatf("b56_c2_b%0d", i));
    rd(14, 32'h1C0, "b56_c2_b14");
    rd(15, 32'h0, "b56_c2_b15");
    release_chunk();
    wait_msg_done("b56");
    chk("b56_starts", 64'(n_starts - base), 64'd2);
    chk("b56_count", {48'd0, chunk_count}, CNT ? 64'd2 : 64'd0);

    // 64 bytes, with in_valid held and stale crunch_done during START/WAIT
    do_reset();
    base = n_starts;
    for (int i = 0; i < 16; i++) send(32'h0A0B0C00 | 32'(i), (i == 15), 2'd0);
    wait_start("b64_c1");
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b0; crunch_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    crunch_done = 1'b0;
    chk("b64_busy_ready0", {63'd0, in_ready}, 64'd0);
    repeat (3) @(negedge clk);
    chk("b64_busy_ready1", {63'd0, in_ready}, 64'd0);
    rd(0, 32'h0A0B0C00, "b64_c1_b0");
    rd(15, 32'h0A0B0C0F, "b64_c1_b15");
    in_valid = 1'b0;
    release_chunk();
    wait_start("b64_c2");
    rd(0, 32'h80, "b64_c2_b0");
    rd(1, 32'h0, "b64_c2_b1");
    rd(14, 32'h200, "b64_c2_b14");
    rd(15, 32'h0, "b64_c2_b15");
    release_chunk();
    wait_msg_done("b64");
    chk("b64_starts", 64'(n_starts - base), 64'd2);
    chk("b64_count", {48'd0, chunk_count}, CNT ? 64'd2 : 64'd0);

    // reset during BUSY of chunk 1 abandons the message
    do_reset();
    for (int i = 0; i < 16; i++) send(32'h5A5A0000 | 32'(i), (i == 15), 2'd0);
    wait_start("rstb");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    base = n_starts;
    chk("rstb_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rstb_msg_done", {63'd0, msg_done}, 64'd0);
    chk("rstb_count", {48'd0, chunk_count}, 64'd0);
    crunch_done = 1'b1;
    repeat (2) @(negedge clk);
    crunch_done = 1'b0;
    repeat (40) @(negedge clk);
    chk("rstb_no_start", 64'(n_starts - base), 64'd0);
    chk("rstb_in_ready_late", {63'd0, in_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
